// File: rtl/sti_lane_tx.sv
// Serial lane transmitter: queues framed parallel words and streams each frame
// over LANES serial lanes, back-to-back, with an output stall.
module sti_lane_tx #(
    parameter int DATA_W     = 16,
    parameter int LANES      = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic [DATA_W-1:0]             pi_data,
    input  logic [1:0]                    pi_length,
    input  logic                          pi_fill,
    input  logic                          pi_msb,
    input  logic                          pi_low,
    input  logic                          pi_end,
    input  logic                          so_stall,
    output logic                          pi_ready,
    output logic [LANES-1:0]              so_data,
    output logic                          so_valid,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          tx_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_W + 6;
    localparam int FW = 2 * DATA_W;
    localparam int CW = $clog2(FW / LANES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic [1:0]    state_q, state_d;
    logic [FW-1:0] sh_q, sh_d;
    logic [CW-1:0] beat_q, beat_d, nb_q, nb_d;
    logic          fend_q, fend_d, end_seen_q, end_seen_d;

    logic full, empty, push, pop, beat_fire, last_beat;
    logic [EW-1:0] head;
    logic [DATA_W-1:0] h_data;
    logic [1:0]    h_len;
    logic          h_fill, h_msb, h_low, h_end;
    logic [FW-1:0] frame, frame_rev, sh_init;
    logic [CW-1:0] nb_init;
    int            flen;

    assign full     = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign empty    = (cnt_q == '0);
    assign pi_ready = !full && !end_seen_q;
    assign push     = load && pi_ready;

    assign head = mem_q[rd_q];
    assign {h_data, h_len, h_fill, h_msb, h_low, h_end} = head;

    assign beat_fire = (state_q == S_SHIFT) && !so_stall;
    assign last_beat = (beat_q == nb_q - CW'(1));
    assign pop       = !empty && ((state_q == S_IDLE) || (beat_fire && last_beat));

    // Build the frame LSB-aligned, then left-align it so the first bit to send sits at the top.
    always_comb begin
        frame   = '0;
        flen    = DATA_W;
        nb_init = CW'(DATA_W / LANES);
        case (h_len)
            2'd0: begin
                frame[DATA_W/2-1:0] = h_low ? h_data[DATA_W-1:DATA_W/2] : h_data[DATA_W/2-1:0];
                flen    = DATA_W / 2;
                nb_init = CW'(DATA_W / 2 / LANES);
            end
            2'd1: frame = FW'(h_data);
            2'd2: begin
                frame   = FW'(h_data) << (h_fill ? DATA_W / 2 : 0);
                flen    = 3 * DATA_W / 2;
                nb_init = CW'(3 * DATA_W / 2 / LANES);
            end
            default: begin
                frame   = FW'(h_data) << (h_fill ? DATA_W : 0);
                flen    = FW;
                nb_init = CW'(FW / LANES);
            end
        endcase
        frame_rev = '0;
        for (int i = 0; i < FW; i++) frame_rev[i] = frame[FW-1-i];
        sh_init = h_msb ? (frame << (FW - flen)) : frame_rev;
    end

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        beat_d     = beat_q;
        nb_d       = nb_q;
        fend_d     = fend_q;
        end_seen_d = end_seen_q || (push && pi_end);
        if (pop) begin
            state_d = S_SHIFT;
            sh_d    = sh_init;
            beat_d  = '0;
            nb_d    = nb_init;
            fend_d  = h_end;
        end else if (beat_fire) begin
            if (last_beat) begin
                state_d = fend_q ? S_DONE : S_IDLE;
            end else begin
                beat_d = beat_q + CW'(1);
                sh_d   = sh_q << LANES;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            state_q    <= S_IDLE;
            sh_q       <= '0;
            beat_q     <= '0;
            nb_q       <= '0;
            fend_q     <= 1'b0;
            end_seen_q <= 1'b0;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
            state_q    <= state_d;
            sh_q       <= sh_d;
            beat_q     <= beat_d;
            nb_q       <= nb_d;
            fend_q     <= fend_d;
            end_seen_q <= end_seen_d;
        end
    end

    assign so_valid   = beat_fire;
    assign so_data    = so_valid ? sh_q[FW-1 -: LANES] : '0;
    assign busy       = (state_q == S_SHIFT);
    assign tx_done    = (state_q == S_DONE);
    assign fifo_level = cnt_q;

endmodule

// File: tb/tb_sti_lane_tx.sv
// Directed bench for sti_lane_tx: one LANES=1 and one LANES=2 instance.
module tb_sti_lane_tx;
    logic        clk = 1'b0;
    logic        reset, load1, load2, stall;
    logic [15:0] d;
    logic [1:0]  len;
    logic        fill, msb, low, pend;
    logic        rdy1, rdy2, v1, v2, busy1, busy2, done1, done2;
    logic [0:0]  sd1;
    logic [1:0]  sd2;
    logic [2:0]  lvl1, lvl2;
    logic [7:0]  pat [6];
    int          total = 0, npass = 0, cnt;

    always #5 clk = ~clk;

    sti_lane_tx #(.DATA_W(16), .LANES(1), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .reset(reset), .load(load1), .pi_data(d), .pi_length(len),
        .pi_fill(fill), .pi_msb(msb), .pi_low(low), .pi_end(pend), .so_stall(stall),
        .pi_ready(rdy1), .so_data(sd1), .so_valid(v1), .busy(busy1),
        .fifo_level(lvl1), .tx_done(done1));

    sti_lane_tx #(.DATA_W(16), .LANES(2), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .reset(reset), .load(load2), .pi_data(d), .pi_length(len),
        .pi_fill(fill), .pi_msb(msb), .pi_low(low), .pi_end(pend), .so_stall(1'b0),
        .pi_ready(rdy2), .so_data(sd2), .so_valid(v2), .busy(busy2),
        .fifo_level(lvl2), .tx_done(done2));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin npass++; end
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic setw(input logic [15:0] wd, input logic [1:0] wl, input logic wf,
                        input logic wm, input logic wlo, input logic we);
        d = wd; len = wl; fill = wf; msb = wm; low = wlo; pend = we;
    endtask

    // Expected bits listed earliest-first from the top of exp; lanes taken LANES at a time.
    task automatic beats(input string tag, input int dut, input logic [31:0] exp, input int n);
        int ln;
        ln = (dut == 2) ? 2 : 1;
        for (int i = 0; i < n; i++) begin
            if (dut == 2) begin
                chk($sformatf("%s_v%0d", tag, i), 64'(v2), 64'd1);
                chk($sformatf("%s_d%0d", tag, i), 64'(sd2), 64'(exp[ln*(n-1-i) +: 2]));
            end else begin
                chk($sformatf("%s_v%0d", tag, i), 64'(v1), 64'd1);
                chk($sformatf("%s_d%0d", tag, i), 64'(sd1), 64'(exp[n-1-i]));
            end
            tick;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; load1 = 1'b0; load2 = 1'b0; stall = 1'b0;
        setw(16'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        pat[0] = 8'h81; pat[1] = 8'h42; pat[2] = 8'h24;
        pat[3] = 8'h18; pat[4] = 8'hFF; pat[5] = 8'h5A;
        tick; tick;
        chk("rst_valid", 64'(v1), 64'd0);
        chk("rst_data", 64'(sd1), 64'd0);
        chk("rst_busy", 64'(busy1), 64'd0);
        chk("rst_done", 64'(done1), 64'd0);
        chk("rst_level", 64'(lvl1), 64'd0);
        reset = 1'b0;
        #1;
        chk("rst_ready", 64'(rdy1), 64'd1);

        // Half word, low half, MSB first
        setw(16'hA5C3, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        load1 = 1'b1; tick; load1 = 1'b0;
        chk("t1_lat_valid", 64'(v1), 64'd0);
        chk("t1_lat_level", 64'(lvl1), 64'd1);
        tick;
        beats("t1", 1, 32'hC3, 8);
        chk("t1_after_valid", 64'(v1), 64'd0);
        chk("t1_after_busy", 64'(busy1), 64'd0);

        // 24-bit frames with fill in MSBs, then in LSBs
        setw(16'h8001, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        load1 = 1'b1; tick; load1 = 1'b0; tick;
        beats("t2f1", 1, 32'h800100, 24);
        chk("t2f1_after", 64'(v1), 64'd0);
        setw(16'h8001, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        load1 = 1'b1; tick; load1 = 1'b0; tick;
        beats("t2f0", 1, 32'h008001, 24);
        chk("t2f0_after", 64'(v1), 64'd0);

        // Two lanes, full word, LSB first
        setw(16'hA5C3, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        load2 = 1'b1; tick; load2 = 1'b0; tick;
        beats("t3", 2, 32'hC3A5, 8);
        chk("t3_after", 64'(v2), 64'd0);

        // Fill under stall, then drain back-to-back
        stall = 1'b1;
        for (int k = 0; k < 6; k++) begin
            setw({8'h00, pat[k]}, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
            if (k == 5) begin
                chk("t4_ready_full", 64'(rdy1), 64'd0);
                chk("t4_level_full", 64'(lvl1), 64'd4);
            end
            load1 = 1'b1; tick;
        end
        load1 = 1'b0;
        chk("t4_level_hold", 64'(lvl1), 64'd4);
        chk("t4_busy", 64'(busy1), 64'd1);
        chk("t4_stall_valid", 64'(v1), 64'd0);
        chk("t4_stall_data", 64'(sd1), 64'd0);
        stall = 1'b0;
        #1;
        for (int f = 0; f < 5; f++) begin
            for (int b = 0; b < 8; b++) begin
                chk($sformatf("t4_v%0d_%0d", f, b), 64'(v1), 64'd1);
                chk($sformatf("t4_d%0d_%0d", f, b), 64'(sd1), 64'(pat[f][7-b]));
                tick;
            end
        end
        chk("t4_after", 64'(v1), 64'd0);

        // End-marked third word, high halves
        stall = 1'b1;
        setw(16'h9A00, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0); load1 = 1'b1; tick;
        setw(16'h5500, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0); tick;
        setw(16'hC300, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1); tick;
        load1 = 1'b0;
        chk("t5_ready_end", 64'(rdy1), 64'd0);
        chk("t5_level", 64'(lvl1), 64'd2);
        chk("t5_done_pre", 64'(done1), 64'd0);
        stall = 1'b0;
        #1;
        beats("t5", 1, 32'h9A55C3, 24);
        chk("t5_done", 64'(done1), 64'd1);
        chk("t5_done_valid", 64'(v1), 64'd0);
        chk("t5_done_busy", 64'(busy1), 64'd0);
        setw(16'hFFFF, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        load1 = 1'b1; tick; load1 = 1'b0;
        chk("t5_ignored_level", 64'(lvl1), 64'd0);
        chk("t5_ignored_ready", 64'(rdy1), 64'd0);
        tick;
        chk("t5_done_hold", 64'(done1), 64'd1);
        chk("t5_done_quiet", 64'(v1), 64'd0);

        // Reset mid-frame with two words queued
        reset = 1'b1; tick; reset = 1'b0;
        chk("t6_done_clr", 64'(done1), 64'd0);
        stall = 1'b1;
        setw(16'h1234, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        load1 = 1'b1; tick; tick; tick; load1 = 1'b0;
        chk("t6_level", 64'(lvl1), 64'd2);
        stall = 1'b0;
        #1;
        tick; tick; tick; tick;
        chk("t6_beat5_valid", 64'(v1), 64'd1);
        chk("t6_beat5_data", 64'(sd1), 64'd0);
        reset = 1'b1; tick;
        chk("t6_rst_valid", 64'(v1), 64'd0);
        chk("t6_rst_level", 64'(lvl1), 64'd0);
        chk("t6_rst_ready", 64'(rdy1), 64'd1);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (v1) cnt++;
        end
        chk("t6_silent", 64'(cnt), 64'd0);
        chk("t6_busy", 64'(busy1), 64'd0);

        $display("%0d/%0d checks passed", npass, total);
        $finish;
    end
endmodule

// File: doc/sti_lane_tx.md
Name: sti_lane_tx

Overview:
- Parametrised successor of the serial transmitter (STI) front end.
- Accepts parallel words with per-word framing controls (length, fill, bit order, half select) into a small input FIFO, then streams each frame serially over 1, 2 or 4 lanes.
- Back-to-back frames go out with no idle gap, and the output supports a stall input.
- Sits between the pattern/stimulus loader and the downstream data-arrangement (ODD/EVEN memory) controller.

Parameters:
- DATA_W, 16, input word width; even; DATA_W/2 divisible by LANES.
- LANES, 1, serial lanes per beat; legal values 1, 2, 4.
- FIFO_DEPTH, 4, input FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- load  in  1  word offer; accepted on an edge where load && pi_ready.
- pi_data  in  DATA_W  parallel word.
- pi_length  in  2  frame length: 0=DATA_W/2, 1=DATA_W, 2=3*DATA_W/2, 3=2*DATA_W bits.
- pi_fill  in  1  1: data in MSBs, zero pad in LSBs; 0: zero pad in MSBs.
- pi_msb  in  1  1: MSB transmitted first; 0: LSB first.
- pi_low  in  1  length 0 only: 1 selects pi_data[DATA_W-1:DATA_W/2], 0 selects the low half.
- pi_end  in  1  sampled with an accepted load; marks that word as the last frame.
- so_stall  in  1  freezes the output beat when high.
- pi_ready  out  1  high while FIFO not full and no end-marked word accepted yet.
- so_data  out  LANES  serial beat; lane LANES-1 carries the earliest-ordered bit of the beat.
- so_valid  out  1  so_data valid this cycle.
- busy  out  1  shifter holds a frame (SHIFT state).
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- tx_done  out  1  level; high after the last frame's final beat.

Behaviour:
- Reset values: so_data=0, so_valid=0, busy=0, tx_done=0, fifo_level=0, FIFO empty, end flag clear, state IDLE.
- pi_ready is combinational: !full && !end_seen. It is 1 in the first cycle after reset deasserts.
- Reset during any state discards the FIFO and the current frame; so_valid is 0 in the cycle after the reset edge.
- Push: on load && pi_ready, store {pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end}. If pi_end=1, set end_seen.
- pi_ready ignores a same-cycle pop: full stays blocking even when a pop occurs on that edge.
- Frame build from the popped entry, L = frame length in bits:
  - length 0: the selected half.
  - length 1: whole word.
  - length 2/3: word plus zero pad up to L. pi_fill=1 puts data in the MSBs; pi_fill=0 puts data in the LSBs.
  - The built frame is L bits; order is per pi_msb.
- Each frame is sent as L/LANES beats, LANES bits per beat, on consecutive non-stalled cycles.
- States:
  - IDLE: so_valid=0. If FIFO non-empty, pop, load shifter, go to SHIFT. This happens even if so_stall=1.
  - SHIFT: so_valid=1 unless so_stall. A non-stalled beat advances beat_cnt.
    - On the last beat: if FIFO non-empty, pop and reload in the same edge and stay in SHIFT (zero gap). Else, if the finished frame was end-marked, go to DONE. Else go to IDLE.
  - DONE: tx_done=1, so_valid=0, pi_ready=0. Exit only by reset.
- Stall: while so_stall=1, so_valid=0 and so_data, beat_cnt and the shifter hold. The same beat is presented when the stall drops.
- Latency: a word accepted at edge N into an empty FIFO with state IDLE is popped at edge N+1. Its first beat is valid in the cycle after edge N+1.
- so_data is 0 whenever so_valid=0.
- fifo_level updates on the edge of a push or pop. Simultaneous push and pop leaves it unchanged.

Test Plan:
- DATA_W=16, LANES=1: load 16'hA5C3, length 0, low=0, msb=1 -> 8 consecutive beats 1,1,0,0,0,0,1,1; first beat 2 cycles after the load edge; so_valid low afterwards.
- DATA_W=16, LANES=1: 16'h8001, length 2, fill=1, msb=1 -> 24 beats: 1, fourteen 0s, 1, eight 0s. Same word with fill=0 -> eight 0s first, then 1000000000000001.
- DATA_W=16, LANES=2: 16'hA5C3, length 1, msb=0 -> 8 beats 11,00,00,11,10,10,01,01.
- LANES=1, FIFO_DEPTH=4, so_stall=1, offer 6 loads -> 5 accepted (1 in shifter, 4 queued), pi_ready=0 on the 6th, fifo_level=4. Release stall -> all frames sent with no so_valid gap between them.
- Three length-0 words, the third with pi_end=1 -> pi_ready=0 after the third accept; tx_done rises the cycle after the 24th beat and stays high; later loads are ignored.
- Assert reset mid-frame on beat 5 of 16 with 2 words queued -> the next cycle has so_valid=0, fifo_level=0, pi_ready=1, and nothing further is emitted.
